m_mem_unit: RTL and testbench

- M-stage load/store unit of the P7 pipeline. Sits between the E/M pipeline register and the M/W register, and produces m_memRd.
- Runs one bus transaction per memory instruction over a req/ack bridge bus, and stalls the pipeline until the transaction completes.
- Performs byte-lane steering for stores and sign/zero extension for loads.
- Detects address exceptions (AdEL/AdES) and reports them to CP0.

---
 rtl/m_mem_unit_if.sv | 21 ++
 rtl/m_mem_unit.sv | 181 ++++++++++++++++++
 tb/tb_m_mem_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/m_mem_unit_if.sv
// Request/acknowledge bridge bus between the M-stage load/store unit and the
// system bridge (data memory, timers, interrupt generator).
interface m_mem_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, byteen, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, byteen, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/m_mem_unit.sv
// M-stage load/store unit: one bridge transaction per memory instruction,
// pipeline stall until done, store lane steering, load extension, AdEL/AdES.
module m_mem_unit #(
    parameter logic [31:0] DM_END   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              m_valid,
    input  logic              m_load,
    input  logic              m_store,
    input  logic [1:0]        m_width,
    input  logic              m_sign,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_wdata,
    m_mem_unit_if.master      bus,
    output logic [31:0]       m_memRd,
    output logic              stall,
    output logic              exc,
    output logic [4:0]        exc_code
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  width_q, width_d;
    logic        sign_q, sign_d;
    logic        we_q, we_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        abort_q, abort_d;
    logic [31:0] memrd_q, memrd_d;

    logic        acc;
    logic        in_dm, in_tc, in_ig;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wd;
    logic [31:0] load_ext;

    assign acc = m_valid & (m_load | m_store);

    // Timer windows are 16-byte aligned; offsets 0/4/8 are registers, 12 is a hole.
    always_comb begin
        in_dm = (m_addr <= DM_END);
        in_tc = ((m_addr >= TC0_BASE) && (m_addr < TC0_BASE + 32'd12)) ||
                ((m_addr >= TC1_BASE) && (m_addr < TC1_BASE + 32'd12));
        in_ig = (m_addr >= IG_BASE) && (m_addr < IG_BASE + 32'd4);
        case (m_width)
            2'd0:    misaligned = (m_addr[1:0] != 2'b00);
            2'd1:    misaligned = m_addr[0];
            default: misaligned = 1'b0;
        endcase
        exc = acc & (misaligned
                     | !(in_dm | in_tc | in_ig)
                     | (in_tc & (m_width != 2'd0))
                     | (in_tc & m_store & (m_addr[3:2] == 2'b10)));
        exc_code = exc ? (m_store ? 5'd5 : 5'd4) : 5'd0;
    end

    always_comb begin
        case (m_width)
            2'd0: begin
                lane_be = 4'b1111;
                lane_wd = m_wdata;
            end
            2'd1: begin
                lane_be = m_addr[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{m_wdata[15:0]}};
            end
            default: begin
                lane_be = 4'b0001 << m_addr[1:0];
                lane_wd = {4{m_wdata[7:0]}};
            end
        endcase
    end

    always_comb begin
        case (width_q)
            2'd0:    load_ext = rdata_q;
            2'd1: begin
                if (addr_q[1])
                    load_ext = {{16{sign_q & rdata_q[31]}}, rdata_q[31:16]};
                else
                    load_ext = {{16{sign_q & rdata_q[15]}}, rdata_q[15:0]};
            end
            default: begin
                load_ext = {24'd0, rdata_q[{addr_q[1:0], 3'b000} +: 8]};
                if (sign_q && load_ext[7])
                    load_ext[31:8] = 24'hFF_FFFF;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        width_d  = width_q;
        sign_d   = sign_q;
        we_d     = we_q;
        byteen_d = byteen_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        abort_d  = abort_q;
        memrd_d  = memrd_q;
        stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc && !exc && !req) begin
                    stall    = 1'b1;
                    addr_d   = m_addr;
                    width_d  = m_width;
                    sign_d   = m_sign;
                    we_d     = m_store;
                    byteen_d = lane_be;
                    wdata_d  = lane_wd;
                    abort_d  = 1'b0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (req)
                    abort_d = 1'b1;
                // The bus cannot be abandoned, so a flush only decides where ack lands.
                if (bus.ack) begin
                    rdata_d = bus.rdata;
                    abort_d = 1'b0;
                    state_d = (abort_q || req) ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (!req && !we_q)
                    memrd_d = load_ext;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            width_q  <= '0;
            sign_q   <= 1'b0;
            we_q     <= 1'b0;
            byteen_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            abort_q  <= 1'b0;
            memrd_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            width_q  <= width_d;
            sign_q   <= sign_d;
            we_q     <= we_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            abort_q  <= abort_d;
            memrd_q  <= memrd_d;
        end
    end

    assign bus.req    = (state_q == S_BUSY);
    assign bus.we     = (state_q == S_BUSY) & we_q;
    assign bus.addr   = {addr_q[31:2], 2'b00};
    assign bus.byteen = byteen_q;
    assign bus.wdata  = wdata_q;

    // The extended value is live in DONE and then held until the next load completes.
    assign m_memRd = ((state_q == S_DONE) && !we_q) ? load_ext : memrd_q;

endmodule

// File: tb/tb_m_mem_unit.sv
// Bench for m_mem_unit: directed scenarios then randomized accesses, each
// checked against an address-map/lane reference model written from the rules.
module tb_m_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        m_valid, m_load, m_store, m_sign;
    logic [1:0]  m_width;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_memRd;
    logic        stall, exc;
    logic [4:0]  exc_code;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_memrd;

    m_mem_unit_if bus_if ();

    m_mem_unit dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .m_valid  (m_valid),
        .m_load   (m_load),
        .m_store  (m_store),
        .m_width  (m_width),
        .m_sign   (m_sign),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .bus      (bus_if.master),
        .m_memRd  (m_memRd),
        .stall    (stall),
        .exc      (exc),
        .exc_code (exc_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int acc_size(input logic [1:0] w);
        return (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
    endfunction

    // Address-map reference: which accesses the system refuses, and with which code.
    function automatic int ref_code(input bit st, input logic [1:0] w, input logic [31:0] a);
        int  sz;
        bit  bad, dm, tc, ig;
        sz = acc_size(w);
        dm = (a <= 32'h2FFF);
        tc = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
        ig = (a >= 32'h7F20 && a < 32'h7F24);
        bad = ((a % sz) != 0) || !(dm || tc || ig) || (tc && sz != 4) ||
              (st && tc && (a % 16) == 8);
        return bad ? (st ? 5 : 4) : 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] w, input logic [31:0] a);
        int sz = acc_size(w);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] w, input logic [31:0] d);
        int sz = acc_size(w);
        logic [31:0] r = 0;
        for (int k = 0; k < 4 / sz; k++)
            r = r | ((d & 32'((64'd1 << (8 * sz)) - 1)) << (8 * sz * k));
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] w, input bit sg,
                                             input logic [31:0] a, input logic [31:0] rd);
        int          sz = acc_size(w);
        logic [31:0] mask, v;
        mask = 32'((64'd1 << (8 * sz)) - 1);
        v = (rd >> (8 * (a % 4))) & mask;
        if (sg && sz < 4 && v[8 * sz - 1])
            v = v | ~mask;
        return v;
    endfunction

    // One full memory instruction; the bridge acks after 'waits' extra BUSY cycles.
    task automatic do_access(input string tag, input bit ld, input bit st, input logic [1:0] w,
                             input bit sg, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int waits);
        int code;
        m_valid = 1'b1; m_load = ld; m_store = st; m_width = w; m_sign = sg;
        m_addr = a; m_wdata = wd; bus_if.ack = 1'b0; bus_if.rdata = '0;
        #1;
        code = ref_code(st, w, a);
        check({tag, ".exc"}, 32'(exc), 32'(code != 0));
        check({tag, ".exc_code"}, 32'(exc_code), 32'(code));
        if (code != 0) begin
            check({tag, ".exc_stall"}, 32'(stall), 32'd0);
            @(posedge clk); #1;
            check({tag, ".exc_noreq"}, 32'(bus_if.req), 32'd0);
            m_valid = 1'b0;
            $display("txn %s ld=%0d st=%0d w=%0d a=%h exc_code=%0d", tag, ld, st, w, a, code);
            return;
        end
        check({tag, ".stall_idle"}, 32'(stall), 32'd1);
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            check({tag, ".req"}, 32'(bus_if.req), 32'd1);
            check({tag, ".stall_busy"}, 32'(stall), 32'd1);
            if (i == 0 || i == waits) begin
                check({tag, ".we"}, 32'(bus_if.we), 32'(st));
                check({tag, ".addr"}, bus_if.addr, a & 32'hFFFF_FFFC);
                check({tag, ".byteen"}, 32'(bus_if.byteen), 32'(ref_be(w, a)));
                if (st)
                    check({tag, ".wdata"}, bus_if.wdata, ref_wd(w, wd));
            end
            bus_if.ack   = (i == waits);
            bus_if.rdata = (i == waits) ? rd : $urandom;
        end
        @(posedge clk); #1;
        bus_if.ack = 1'b0;
        check({tag, ".stall_done"}, 32'(stall), 32'd0);
        check({tag, ".req_done"}, 32'(bus_if.req), 32'd0);
        if (ld && !st) begin
            last_memrd = ref_load(w, sg, a, rd);
            check({tag, ".memrd"}, m_memRd, last_memrd);
        end
        m_valid = 1'b0;
        @(posedge clk); #1;
        if (ld && !st)
            check({tag, ".memrd_hold"}, m_memRd, last_memrd);
        $display("txn %s ld=%0d st=%0d w=%0d a=%h waits=%0d memrd=%h", tag, ld, st, w, a, waits, m_memRd);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  w;
        bit          ld;
        int          region;

        reset = 1'b1; req = 1'b0; m_valid = 1'b0; m_load = 1'b0; m_store = 1'b0;
        m_width = 2'd0; m_sign = 1'b0; m_addr = '0; m_wdata = '0;
        bus_if.ack = 1'b0; bus_if.rdata = '0;
        last_memrd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req", 32'(bus_if.req), 32'd0);
        check("rst.we", 32'(bus_if.we), 32'd0);
        check("rst.addr", bus_if.addr, 32'd0);
        check("rst.byteen", 32'(bus_if.byteen), 32'd0);
        check("rst.wdata", bus_if.wdata, 32'd0);
        check("rst.memrd", m_memRd, 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_access("sw_0x10", 0, 1, 2'd0, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        do_access("lb_0x13", 1, 0, 2'd2, 1, 32'h13, 32'h0, 32'h80FF_0000, 3);
        do_access("lh_0x11", 1, 0, 2'd1, 1, 32'h11, 32'h0, 32'h0, 0);
        do_access("sw_cnt", 0, 1, 2'd0, 0, 32'h7F08, 32'h1234, 32'h0, 0);
        do_access("sb_tc0", 0, 1, 2'd2, 0, 32'h7F04, 32'h55, 32'h0, 0);
        do_access("lw_3000", 1, 0, 2'd0, 0, 32'h3000, 32'h0, 32'h0, 0);
        do_access("sh_ig_past", 0, 1, 2'd1, 0, 32'h7F24, 32'hABCD, 32'h0, 0);
        do_access("sh_0x2002", 0, 1, 2'd1, 0, 32'h2002, 32'hCAFE_F00D, 32'h0, 1);
        do_access("sb_ig_last", 0, 1, 2'd2, 0, 32'h7F23, 32'h0000_00A5, 32'h0, 0);
        do_access("lw_cnt", 1, 0, 2'd0, 0, 32'h7F18, 32'h0, 32'h0BAD_F00D, 2);
        do_access("lhu_dmend", 1, 0, 2'd1, 0, 32'h2FFE, 32'h0, 32'h8001_7FFF, 0);

        // Flush while BUSY: transaction completes on the bus, result discarded, no DONE.
        m_valid = 1'b1; m_load = 1'b1; m_store = 1'b0; m_width = 2'd0; m_sign = 1'b0;
        m_addr = 32'h40; m_wdata = '0;
        #1;
        check("abort.stall_idle", 32'(stall), 32'd1);
        @(posedge clk); #1;
        req = 1'b1;
        check("abort.req1", 32'(bus_if.req), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        check("abort.req2", 32'(bus_if.req), 32'd1);
        check("abort.stall2", 32'(stall), 32'd1);
        @(posedge clk); #1;
        bus_if.ack = 1'b1; bus_if.rdata = 32'h7777_7777;
        check("abort.req3", 32'(bus_if.req), 32'd1);
        check("abort.stall3", 32'(stall), 32'd1);
        @(posedge clk); #1;
        bus_if.ack = 1'b0; m_valid = 1'b0;
        #1;
        check("abort.stall_after", 32'(stall), 32'd0);
        check("abort.req_after", 32'(bus_if.req), 32'd0);
        check("abort.memrd_kept", m_memRd, last_memrd);
        @(posedge clk); #1;
        check("abort.no_restart", 32'(bus_if.req), 32'd0);
        check("abort.memrd_kept2", m_memRd, last_memrd);
        $display("txn abort_lw a=00000040 memrd=%h", m_memRd);

        // Reset while BUSY.
        m_valid = 1'b1; m_load = 1'b1; m_width = 2'd0; m_addr = 32'h44;
        @(posedge clk); #1;
        check("rstbusy.req_before", 32'(bus_if.req), 32'd1);
        reset = 1'b1; m_valid = 1'b0;
        @(posedge clk); #1;
        check("rstbusy.req", 32'(bus_if.req), 32'd0);
        check("rstbusy.stall", 32'(stall), 32'd0);
        check("rstbusy.memrd", m_memRd, 32'd0);
        reset = 1'b0; last_memrd = '0;
        @(posedge clk); #1;
        check("rstbusy.idle", 32'(bus_if.req), 32'd0);
        $display("txn reset_busy a=00000044 memrd=%h", m_memRd);

        for (int n = 0; n < 40; n++) begin
            region = $urandom_range(0, 5);
            case (region)
                0:       a = 32'($urandom_range(0, 32'h2FFF));
                1:       a = 32'h2FF8 + 32'($urandom_range(0, 15));
                2:       a = 32'h7F00 + 32'($urandom_range(0, 15));
                3:       a = 32'h7F10 + 32'($urandom_range(0, 15));
                4:       a = 32'h7F1C + 32'($urandom_range(0, 11));
                default: a = $urandom;
            endcase
            w = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0)
                a = a & ~32'(acc_size(w) - 1);
            ld = 1'($urandom_range(0, 1));
            do_access($sformatf("rnd%0d", n), ld, !ld, w, 1'($urandom_range(0, 1)), a,
                      $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
